// File: rtl/pixel_stream_tx_pkg.sv
// Shared definitions for the pixel load path into the edge/colour chip.
// Holds the default image geometry, the chip mode encodings and the
// transmitter state encoding, plus a helper for the beat count.
package pixel_stream_tx_pkg;

  localparam int unsigned DEF_IMG_DIM      = 20;
  localparam int unsigned DEF_BIT_LENGTH   = 5;
  localparam int unsigned DEF_PIX_PER_BEAT = 3;
  localparam int unsigned DEF_NUM_PIX      = DEF_IMG_DIM * DEF_IMG_DIM;

  typedef enum logic {
    MODE_EDGE  = 1'b0,
    MODE_COLOR = 1'b1
  } chip_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFETCH,
    ST_ALIGN,
    ST_STREAM
  } tx_state_e;

  // Number of 3-pixel beats needed to carry num_pix pixels.
  function automatic int unsigned num_beats(input int unsigned num_pix);
    return (num_pix + DEF_PIX_PER_BEAT - 1) / DEF_PIX_PER_BEAT;
  endfunction

  localparam int unsigned DEF_NUM_BEATS = num_beats(DEF_NUM_PIX);

endpackage

// File: rtl/pixel_stream_tx_beat_unpack.sv
// beat_unpack: splits one packed memory word into the three pixels of a
// beat. Pixel indices at or beyond NUM_PIX are forced to zero, which blanks
// the unused tail of the final word.
// Ports:
//   beat_idx  in   beat number k (pixels 3k, 3k+1, 3k+2)
//   word      in   packed word, pixel 3k in the low BIT_LENGTH bits
//   pix0..2   out  pixels 3k, 3k+1, 3k+2 (zero when out of range)
module beat_unpack
  import pixel_stream_tx_pkg::*;
#(
  parameter int unsigned BIT_LENGTH = DEF_BIT_LENGTH,
  parameter int unsigned NUM_PIX    = DEF_NUM_PIX
) (
  input  logic [7:0]              beat_idx,
  input  logic [3*BIT_LENGTH-1:0] word,
  output logic [BIT_LENGTH-1:0]   pix0,
  output logic [BIT_LENGTH-1:0]   pix1,
  output logic [BIT_LENGTH-1:0]   pix2
);

  int unsigned base;

  always_comb begin
    base = 32'(beat_idx) * 3;
    pix0 = (base     < NUM_PIX) ? word[BIT_LENGTH-1:0]              : '0;
    pix1 = (base + 1 < NUM_PIX) ? word[2*BIT_LENGTH-1:BIT_LENGTH]   : '0;
    pix2 = (base + 2 < NUM_PIX) ? word[3*BIT_LENGTH-1:2*BIT_LENGTH] : '0;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: host-side transmitter that streams one image into the
// edge/colour chip three pixels per clock. Words are prefetched from a
// synchronous image memory one cycle ahead so that beats are gapless; a
// one-cycle chip_reset aligns the chip's free-running load index to pixel 0
// on the first beat.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, mode_sel       one-cycle job request and its mode (0 EDGE, 1 COLOR)
//   mem_rd_en, mem_addr   image memory read strobe and word address
//   mem_rdata             packed word, valid the cycle after mem_rd_en
//   chip_reset            alignment reset to the chip
//   mode                  chip mode, held from an accepted start onward
//   pixel_in0..2          registered beat pixels
//   load_end              high on the final beat only
//   busy, done            job in progress / one-cycle completion pulse
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int unsigned IMG_DIM      = DEF_IMG_DIM,
  parameter int unsigned BIT_LENGTH   = DEF_BIT_LENGTH,
  parameter int unsigned PIX_PER_BEAT = DEF_PIX_PER_BEAT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               mode_sel,
  output logic                               mem_rd_en,
  output logic [7:0]                         mem_addr,
  input  logic [PIX_PER_BEAT*BIT_LENGTH-1:0] mem_rdata,
  output logic                               chip_reset,
  output logic                               mode,
  output logic [BIT_LENGTH-1:0]              pixel_in0,
  output logic [BIT_LENGTH-1:0]              pixel_in1,
  output logic [BIT_LENGTH-1:0]              pixel_in2,
  output logic                               load_end,
  output logic                               busy,
  output logic                               done
);

  localparam int unsigned NUM_PIX   = IMG_DIM * IMG_DIM;
  localparam int unsigned NUM_BEATS = num_beats(NUM_PIX);
  localparam logic [7:0]  LAST_BEAT = 8'(NUM_BEATS - 1);
  localparam logic [7:0]  LAST_ADDR = 8'(NUM_BEATS - 1);
  // Beat k reads word k+2, so the last reading beat is NUM_BEATS-3.
  localparam logic [7:0]  LAST_RD_BEAT = 8'(NUM_BEATS - 3);

  tx_state_e             state;
  tx_state_e             state_nxt;
  chip_mode_e            mode_q;
  logic [7:0]            beat_cnt;
  logic [7:0]            rd_addr;
  logic [7:0]            unpack_idx;
  logic                  last_beat;
  logic [BIT_LENGTH-1:0] up0;
  logic [BIT_LENGTH-1:0] up1;
  logic [BIT_LENGTH-1:0] up2;

  assign mem_addr  = rd_addr;
  assign mode      = mode_q;
  assign last_beat = (state == ST_STREAM) && (beat_cnt == LAST_BEAT);

  beat_unpack #(
    .BIT_LENGTH (BIT_LENGTH),
    .NUM_PIX    (NUM_PIX)
  ) u_unpack (
    .beat_idx (unpack_idx),
    .word     (mem_rdata),
    .pix0     (up0),
    .pix1     (up1),
    .pix2     (up2)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    chip_reset = 1'b0;
    mem_rd_en  = 1'b0;
    // The pixel registers always load the beat after the one on the wire.
    unpack_idx = beat_cnt + 8'd1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        mem_rd_en = 1'b1;
        state_nxt = ST_ALIGN;
      end
      ST_ALIGN: begin
        chip_reset = 1'b1;
        mem_rd_en  = 1'b1;
        unpack_idx = '0;
        state_nxt  = ST_STREAM;
      end
      ST_STREAM: begin
        mem_rd_en = (beat_cnt <= LAST_RD_BEAT);
        if (beat_cnt == LAST_BEAT) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_EDGE;
      beat_cnt  <= '0;
      rd_addr   <= '0;
      pixel_in0 <= '0;
      pixel_in1 <= '0;
      pixel_in2 <= '0;
      load_end  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= last_beat;

      if (state == ST_IDLE && start) begin
        mode_q   <= chip_mode_e'(mode_sel);
        beat_cnt <= '0;
        rd_addr  <= '0;
      end

      // Address parks on the last word so it never leaves the memory range.
      if (mem_rd_en && rd_addr != LAST_ADDR) rd_addr <= rd_addr + 8'd1;

      if (state == ST_STREAM) beat_cnt <= beat_cnt + 8'd1;

      if (state == ST_ALIGN || (state == ST_STREAM && !last_beat)) begin
        pixel_in0 <= up0;
        pixel_in1 <= up1;
        pixel_in2 <= up2;
        load_end  <= (unpack_idx == LAST_BEAT);
      end else begin
        pixel_in0 <= '0;
        pixel_in1 <= '0;
        pixel_in2 <= '0;
        load_end  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
module tb_pixel_stream_tx;

  localparam int unsigned NBEATS = 134;
  localparam int unsigned NPIX   = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mode_sel;
  logic       mem_rd_en;
  logic [7:0] mem_addr;
  logic [14:0] mem_rdata = '0;
  logic       chip_reset;
  logic       mode;
  logic [4:0] pixel_in0;
  logic [4:0] pixel_in1;
  logic [4:0] pixel_in2;
  logic       load_end;
  logic       busy;
  logic       done;

  pixel_stream_tx #(
    .IMG_DIM      (20),
    .BIT_LENGTH   (5),
    .PIX_PER_BEAT (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode_sel   (mode_sel),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .chip_reset (chip_reset),
    .mode       (mode),
    .pixel_in0  (pixel_in0),
    .pixel_in1  (pixel_in1),
    .pixel_in2  (pixel_in2),
    .load_end   (load_end),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Image memory: one pixel array (two spare entries fill the last word's
  // unused slots with non-zero data) and the packed word view of it.
  logic [4:0]  img [0:3*NBEATS-1];
  logic [14:0] mem [0:NBEATS-1];
  int unsigned oob_cnt = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      if (mem_addr > 8'd133) begin
        oob_cnt   <= oob_cnt + 1;
        mem_rdata <= '0;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rd_cnt = 0, le_cnt = 0, cr_cnt = 0;
  int unsigned rd0, le0, cr0, oob0;
  logic [15:0] exp_q [$];
  logic [15:0] rx_beats [0:NBEATS-1];
  logic [4:0]  rx_img [0:NPIX-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] pix_exp(input int unsigned idx);
    return (idx < NPIX) ? img[idx] : 5'd0;
  endfunction

  task automatic build_mem();
    for (int unsigned k = 0; k < NBEATS; k++)
      mem[k] = {img[3*k+2], img[3*k+1], img[3*k]};
  endtask

  // Chip-side receiver: index restarts at 0 on the beat after chip_reset.
  task automatic monitor();
    logic        rx_active = 1'b0;
    int unsigned rx_idx = 0;
    logic [15:0] got, want;
    forever begin
      @(negedge clk);
      got = {load_end, pixel_in2, pixel_in1, pixel_in0};
      if (mem_rd_en)  rd_cnt++;
      if (load_end)   le_cnt++;
      if (chip_reset) cr_cnt++;
      if (reset) begin
        rx_active = 1'b0;
        exp_q.delete();
      end else begin
        if (rx_active) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat_unexpected: got %0h with empty queue at %0t", got, $time);
          end else begin
            want = exp_q.pop_front();
            check($sformatf("beat%0d", rx_idx), 32'(got), 32'(want));
          end
          rx_beats[rx_idx] = got;
          for (int unsigned j = 0; j < 3; j++)
            if (3*rx_idx + j < NPIX) rx_img[3*rx_idx + j] = got[5*j +: 5];
          rx_idx++;
          if (rx_idx == NBEATS) rx_active = 1'b0;
        end else begin
          check("idle_outputs", 32'(got), 32'd0);
        end
        if (chip_reset) begin
          rx_active = 1'b1;
          rx_idx    = 0;
        end
      end
    end
  endtask

  task automatic issue_start(input logic msel);
    for (int unsigned k = 0; k < NBEATS; k++)
      exp_q.push_back({1'(k == NBEATS-1), pix_exp(3*k+2), pix_exp(3*k+1), pix_exp(3*k)});
    rd0  = rd_cnt;
    le0  = le_cnt;
    cr0  = cr_cnt;
    oob0 = oob_cnt;
    start    = 1'b1;
    mode_sel = msel;
  endtask

  // Entered just after the start cycle T0; t counts cycles T1..T137.
  task automatic run_job(input logic msel, input int unsigned drop_t, input logic chain,
                         input logic chain_msel, input logic pattern);
    int unsigned errs;
    for (int unsigned t = 1; t <= 137; t++) begin
      @(negedge clk);
      #1;
      case (t)
        1: begin
          check("T1_busy", 32'(busy), 1);
          check("T1_rd_en", 32'(mem_rd_en), 1);
          check("T1_addr", 32'(mem_addr), 0);
          check("T1_chip_reset", 32'(chip_reset), 0);
          check("T1_done", 32'(done), 0);
          check("T1_mode", 32'(mode), 32'(msel));
        end
        2: begin
          check("T2_chip_reset", 32'(chip_reset), 1);
          check("T2_addr", 32'(mem_addr), 1);
        end
        3: check("T3_chip_reset", 32'(chip_reset), 0);
        134: begin
          check("last_read_addr", 32'(mem_addr), 133);
          check("last_read_en", 32'(mem_rd_en), 1);
        end
        135: check("no_read_past_end", 32'(mem_rd_en), 0);
        136: check("T136_load_end", 32'(load_end), 1);
        137: begin
          check("T137_done", 32'(done), 1);
          check("T137_busy", 32'(busy), 0);
          check("T137_mode", 32'(mode), 32'(msel));
          check("rd_en_cycles", rd_cnt - rd0, 134);
          check("load_end_cycles", le_cnt - le0, 1);
          check("chip_reset_cycles", cr_cnt - cr0, 1);
          check("oob_reads", oob_cnt - oob0, 0);
          check("beats_left", exp_q.size(), 0);
          errs = 0;
          for (int unsigned p = 0; p < NPIX; p++) if (rx_img[p] !== img[p]) errs++;
          check("image_rx", errs, 0);
          if (pattern) begin
            check("beat0_hand", 32'(rx_beats[0]), 32'({1'b0, 5'd2, 5'd1, 5'd0}));
            check("beat10_hand", 32'(rx_beats[10]), 32'({1'b0, 5'd0, 5'd31, 5'd30}));
            check("beat133_hand", 32'(rx_beats[133]), 32'({1'b1, 5'd0, 5'd0, 5'd15}));
          end
        end
        default: ;
      endcase
      start    = (t == drop_t);
      mode_sel = (t == drop_t) ? ~msel : msel;
      if (t == 137 && chain) issue_start(chain_msel);
    end
    if (!chain) begin
      @(negedge clk);
      #1;
      check("done_one_cycle", 32'(done), 0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    mode_sel = 1'b0;
    for (int unsigned p = 0; p < 3*NBEATS; p++) img[p] = 5'(p);
    build_mem();
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_chip_reset", 32'(chip_reset), 0);
    check("rst_rd_en", 32'(mem_rd_en), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_pixels", 32'({load_end, pixel_in2, pixel_in1, pixel_in0}), 0);
    reset = 1'b0;

    // Job 1 (COLOR) with a dropped start at T50, chained into job 2 (EDGE).
    @(negedge clk);
    #1;
    issue_start(1'b1);
    run_job(1'b1, 50, 1'b1, 1'b0, 1'b1);
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Job aborted by reset at T80, with a start in the same cycle.
    @(negedge clk);
    #1;
    issue_start(1'b1);
    for (int unsigned t = 1; t <= 81; t++) begin
      @(negedge clk);
      #1;
      start = 1'b0;
      if (t == 80) begin
        check("T80_busy", 32'(busy), 1);
        reset = 1'b1;
        start = 1'b1;
      end
      if (t == 81) begin
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_chip_reset", 32'(chip_reset), 0);
        check("abort_rd_en", 32'(mem_rd_en), 0);
        check("abort_addr", 32'(mem_addr), 0);
        check("abort_mode", 32'(mode), 0);
        check("abort_pixels", 32'({load_end, pixel_in2, pixel_in1, pixel_in0}), 0);
        reset = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    check("post_abort_busy", 32'(busy), 0);
    check("post_abort_chip_reset", 32'(chip_reset), 0);
    issue_start(1'b1);
    run_job(1'b1, 0, 1'b0, 1'b0, 1'b1);

    // Random image through the receiver model.
    for (int unsigned p = 0; p < 3*NBEATS; p++) img[p] = 5'($urandom_range(0, 31));
    build_mem();
    @(negedge clk);
    #1;
    issue_start(1'b0);
    run_job(1'b0, 0, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
